// File: rtl/c2c_pkg.sv
// Shared definitions for the chip-to-chip link controllers.
package c2c_pkg;

    localparam int unsigned C2C_DATA_W              = 3;
    localparam int unsigned C2C_CNT_W               = 28;
    localparam int unsigned C2C_TIMEOUT_CYC_DEFAULT = 200_000_000;
    localparam int unsigned C2C_SETUP_CYC_DEFAULT   = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_SETUP = 3'd2,
        ST_SEND  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ABORT = 3'd5
    } c2c_state_e;

endpackage

// File: rtl/c2c_master_arbiter_sync.sv
// Two-flop synchronizer for a single asynchronous control bit.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/c2c_master_arbiter.sv
// Master-side link controller: round-robin arbitration between two requesters
// and request/ack/data/valid sequencing toward the remote slave, with timeout.
module c2c_master_arbiter
    import c2c_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = C2C_TIMEOUT_CYC_DEFAULT,
    parameter int unsigned SETUP_CYC   = C2C_SETUP_CYC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req,
    input  logic [C2C_DATA_W-1:0] req_data0,
    input  logic [C2C_DATA_W-1:0] req_data1,
    output logic [1:0]            grant,
    output logic                  done,
    output logic                  err,
    output logic                  busy,
    output logic                  link_request,
    input  logic                  link_ack,
    output logic [C2C_DATA_W-1:0] link_data,
    output logic                  link_valid
);

    localparam logic [C2C_CNT_W-1:0] TO_LAST    = C2C_CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [C2C_CNT_W-1:0] SETUP_LAST = C2C_CNT_W'(SETUP_CYC - 1);

    c2c_state_e            state_q, state_d;
    logic [C2C_CNT_W-1:0]  cnt_q;
    logic                  last_q;
    logic                  gnt_idx_q;
    logic                  win_idx;
    logic [C2C_DATA_W-1:0] data_q;
    logic                  ack_s;

    sync_2ff u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (link_ack),
        .q     (ack_s)
    );

    // On a tie the requester not served last time wins.
    always_comb begin
        win_idx = 1'b0;
        case (req)
            2'b01:   win_idx = 1'b0;
            2'b10:   win_idx = 1'b1;
            2'b11:   win_idx = ~last_q;
            default: win_idx = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req != 2'b00) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (ack_s)                  state_d = ST_SETUP;
                else if (cnt_q == TO_LAST)  state_d = ST_ABORT;
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) state_d = ST_SEND;
            end
            ST_SEND: begin
                if (!ack_s)                 state_d = ST_DONE;
                else if (cnt_q == TO_LAST)  state_d = ST_ABORT;
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ABORT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // The counter doubles as setup timer and ack timeout; it restarts on every state change.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            last_q    <= 1'b0;
            gnt_idx_q <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q || state_q == ST_IDLE) cnt_q <= '0;
            else                                          cnt_q <= cnt_q + C2C_CNT_W'(1);
            if (state_q == ST_IDLE && state_d == ST_REQ) begin
                gnt_idx_q <= win_idx;
                data_q    <= win_idx ? req_data1 : req_data0;
            end
            if (state_q == ST_DONE || state_q == ST_ABORT) last_q <= gnt_idx_q;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign grant        = busy ? (gnt_idx_q ? 2'b10 : 2'b01) : 2'b00;
    assign done         = (state_q == ST_DONE);
    assign err          = (state_q == ST_ABORT);
    assign link_request = (state_q == ST_REQ) || (state_q == ST_SETUP);
    assign link_valid   = (state_q == ST_SEND);
    assign link_data    = (state_q == ST_SETUP || state_q == ST_SEND) ? data_q : '0;

endmodule

// File: tb/tb_c2c_master_arbiter.sv
// Self-checking bench: vector table, reset-in-SEND sequence and randomized transfers
// checked cycle by cycle against a transfer-timeline reference model.
module tb_c2c_master_arbiter;

    localparam int TO = 50;
    localparam int SC = 4;

    typedef enum int {M_NORMAL, M_NO_ACK, M_NO_DROP} slave_mode_e;
    typedef enum int {P_IDLE, P_REQ, P_SETUP, P_SEND, P_DONE, P_ABORT} phase_e;

    typedef struct {
        logic [1:0]  req;
        logic [2:0]  d0;
        logic [2:0]  d1;
        int          rise;
        int          fall;
        slave_mode_e mode;
        bit          hold;
        bit          chg;
        logic [2:0]  chg_val;
        bit          early_drop;
        logic [1:0]  exp_grant;
        logic [2:0]  exp_data;
    } tv_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req;
    logic [2:0] req_data0, req_data1;
    logic [1:0] grant;
    logic       done, err, busy, link_request, link_ack, link_valid;
    logic [2:0] link_data;

    int  errors = 0;
    int  checks = 0;
    bit  last_m = 1'b0;
    tv_t vec[9];

    c2c_master_arbiter #(.TIMEOUT_CYC(TO), .SETUP_CYC(SC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_data0    (req_data0),
        .req_data1    (req_data1),
        .grant        (grant),
        .done         (done),
        .err          (err),
        .busy         (busy),
        .link_request (link_request),
        .link_ack     (link_ack),
        .link_data    (link_data),
        .link_valid   (link_valid)
    );

    always #5 clk = ~clk;

    // Output vector layout: {grant, done, err, busy, link_request, link_valid, link_data}
    function automatic logic [9:0] expect_vec(phase_e p, logic [1:0] g, logic [2:0] d);
        case (p)
            P_REQ:   return {g, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0};
            P_SETUP: return {g, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, d};
            P_SEND:  return {g, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, d};
            P_DONE:  return {g, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
            P_ABORT: return {g, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
            default: return 10'd0;
        endcase
    endfunction

    function automatic int pick_winner(logic [1:0] r, bit last);
        if (r == 2'b01) return 0;
        if (r == 2'b10) return 1;
        return last ? 0 : 1;
    endfunction

    task automatic checkOutput(input string tag, input int cyc, input logic [9:0] exp_v);
        logic [9:0] act;
        act = {grant, done, err, busy, link_request, link_valid, link_data};
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, act, exp_v);
        end
    endtask

    // Called at a falling edge with the DUT idle; plays the slave and checks every cycle.
    task automatic applyStimulus(input tv_t v, input string tag);
        int a, vv, e;
        phase_e p;
        req       = v.req;
        req_data0 = v.d0;
        req_data1 = v.d1;
        a  = v.rise + 3;
        vv = a + SC;
        case (v.mode)
            M_NO_ACK:  e = TO;
            M_NO_DROP: e = vv + TO;
            default:   e = vv + v.fall + 3;
        endcase
        for (int i = 0; i <= e + 1; i++) begin
            @(negedge clk);
            if (i == e + 1)                        p = P_IDLE;
            else if (i == e)                       p = (v.mode == M_NORMAL) ? P_DONE : P_ABORT;
            else if (v.mode == M_NO_ACK || i < a)  p = P_REQ;
            else if (i < vv)                       p = P_SETUP;
            else                                   p = P_SEND;
            checkOutput(tag, i, expect_vec(p, v.exp_grant, v.exp_data));
            if (v.mode != M_NO_ACK && i == v.rise)        link_ack = 1'b1;
            if (v.mode == M_NORMAL && i == vv + v.fall)   link_ack = 1'b0;
            if (v.mode == M_NO_DROP && i == e)            link_ack = 1'b0;
            if (v.chg && i == 1) begin
                req_data0 = v.chg_val;
                req_data1 = v.chg_val;
            end
            if (v.early_drop && i == 1) req = 2'b00;
            if (!v.hold && i == e)      req = 2'b00;
        end
        last_m = (v.exp_grant == 2'b10);
    endtask

    initial begin
        bit  seen;
        tv_t rv;
        int  w;

        vec[0] = '{2'b11, 3'd2, 3'd6, 2, 1, M_NORMAL,  1'b1, 1'b0, 3'd0, 1'b0, 2'b10, 3'd6};
        vec[1] = '{2'b11, 3'd2, 3'd6, 2, 1, M_NORMAL,  1'b1, 1'b0, 3'd0, 1'b0, 2'b01, 3'd2};
        vec[2] = '{2'b11, 3'd2, 3'd6, 2, 1, M_NORMAL,  1'b1, 1'b0, 3'd0, 1'b0, 2'b10, 3'd6};
        vec[3] = '{2'b11, 3'd2, 3'd6, 2, 1, M_NORMAL,  1'b0, 1'b0, 3'd0, 1'b0, 2'b01, 3'd2};
        vec[4] = '{2'b01, 3'd5, 3'd0, 10, 5, M_NORMAL, 1'b0, 1'b0, 3'd0, 1'b0, 2'b01, 3'd5};
        vec[5] = '{2'b01, 3'd1, 3'd0, 4, 2, M_NORMAL,  1'b0, 1'b1, 3'd7, 1'b0, 2'b01, 3'd1};
        vec[6] = '{2'b10, 3'd0, 3'd3, 0, 0, M_NO_ACK,  1'b0, 1'b0, 3'd0, 1'b0, 2'b10, 3'd3};
        vec[7] = '{2'b11, 3'd4, 3'd5, 1, 0, M_NO_DROP, 1'b0, 1'b0, 3'd0, 1'b0, 2'b01, 3'd4};
        vec[8] = '{2'b10, 3'd0, 3'd7, 0, 0, M_NORMAL,  1'b0, 1'b0, 3'd0, 1'b1, 2'b10, 3'd7};

        rst_n     = 1'b0;
        req       = 2'b11;
        req_data0 = 3'd2;
        req_data1 = 3'd6;
        link_ack  = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset", 0, 10'd0);
        rst_n = 1'b1;

        for (int t = 0; t < 9; t++) applyStimulus(vec[t], $sformatf("vec%0d", t));

        req       = 2'b01;
        req_data0 = 3'd3;
        seen      = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (link_request) link_ack = 1'b1;
            if (link_valid)   seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL reach_send got valid=0 exp valid=1");
        end
        rst_n = 1'b0;
        req   = 2'b00;
        @(negedge clk);
        checkOutput("rst_in_send", 0, 10'd0);
        rst_n    = 1'b1;
        link_ack = 1'b0;
        last_m   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("idle_no_req", i, 10'd0);
        end
        applyStimulus('{2'b01, 3'd4, 3'd0, 3, 2, M_NORMAL, 1'b0, 1'b0, 3'd0, 1'b0, 2'b01, 3'd4},
                      "after_reset");

        for (int t = 0; t < 25; t++) begin
            rv.req        = 2'($urandom_range(1, 3));
            rv.d0         = 3'($urandom_range(0, 7));
            rv.d1         = 3'($urandom_range(0, 7));
            rv.rise       = $urandom_range(0, 20);
            rv.fall       = $urandom_range(0, 20);
            w             = $urandom_range(0, 9);
            rv.mode       = (w == 0) ? M_NO_ACK : (w == 1) ? M_NO_DROP : M_NORMAL;
            rv.hold       = 1'b0;
            rv.chg        = 1'($urandom_range(0, 1));
            rv.chg_val    = 3'($urandom_range(0, 7));
            rv.early_drop = 1'($urandom_range(0, 1));
            w             = pick_winner(rv.req, last_m);
            rv.exp_grant  = (w == 1) ? 2'b10 : 2'b01;
            rv.exp_data   = (w == 1) ? rv.d1 : rv.d0;
            applyStimulus(rv, $sformatf("rand%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/c2c_master_arbiter.md
# c2c_master_arbiter

Master-side link controller for the chip-to-chip transfer link. It shares one outgoing link between two local requesters using round-robin arbitration. For each granted requester it sequences the full request/ack/data/valid handshake toward the slave controller on the other board. It also enforces a timeout so a dead or unplugged slave cannot hang the master.

## Interface
- `TIMEOUT_CYC`, default 200_000_000: maximum cycles spent waiting on `ack_s` in REQ or SEND before the transfer aborts (2 s at 100 MHz).
- `SETUP_CYC`, default 4: cycles `link_data` is held stable before `link_valid` rises. Must be ≥1.
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous, active-low reset.
- `req` in 2: level request per requester. Held high until that requester sees `done` or `err` with its `grant` bit set.
- `req_data0` in 3: payload of requester 0.
- `req_data1` in 3: payload of requester 1.
- `grant` out 2: one-hot owner of the current transfer; 0 when idle.
- `done` out 1: one-cycle pulse, transfer completed.
- `err` out 1: one-cycle pulse, transfer aborted by timeout.
- `busy` out 1: high whenever state ≠ IDLE.
- `link_request` out 1: request to the slave.
- `link_ack` in 1: ack from the slave. Asynchronous to `clk`.
- `link_data` out 3: data to the slave.
- `link_valid` out 1: data-valid to the slave.

## Operation
- `link_ack` passes through a 2-FF synchronizer to give `ack_s` (reset 0). All FSM decisions use `ack_s` only.
- State IDLE:
  - If `req` is nonzero, grant one requester:
    - If exactly one bit is set, that requester wins.
    - If both are set, the requester not named by `last` wins.
  - `last` is a 1-bit pointer, reset 0, so requester 1 wins the first tie.
  - On grant: latch the winner's data into `data_q` and go to REQ.
- State REQ: `link_request`=1. Wait for `ack_s`=1, then go to SETUP.
- State SETUP: `link_request`=1 and `link_data`=`data_q`. After `SETUP_CYC` cycles, go to SEND.
- State SEND: `link_request`=0, `link_valid`=1, `link_data`=`data_q`. Wait for `ack_s`=0, then go to DONE.
- State DONE (1 cycle): pulse `done`, set `last` to the granted index, go to IDLE.
- State ABORT (1 cycle): pulse `err`; `last` is updated as in DONE; go to IDLE.
- `link_request` drops before `link_valid` rises. This prevents the slave, once it returns to its wait-for-request state, from seeing a stale request and starting a new transfer.
- `link_data` equals `data_q` in SETUP and SEND, and 0 in every other state.
- `grant` holds the one-hot owner from entry to REQ through the DONE or ABORT cycle inclusive. It is 0 in IDLE.
- `data_q` is captured only at grant. Later changes on `req_data*` are ignored.
- Timeout:
  - A 28-bit counter clears on every state change.
  - In REQ or SEND, when it reaches `TIMEOUT_CYC`-1, go to ABORT.
  - `link_request`, `link_valid` and `link_data` are all 0 in ABORT.
- No reordering and no queueing: at most one transfer is in flight.

## Timing
- Reset values: state IDLE, `grant`=0, `done`=0, `err`=0, `busy`=0, `link_request`=0, `link_valid`=0, `link_data`=0, `last`=0, sync flops 0, counter 0.
- All outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.
- Grant latency: `req` high in IDLE at edge N gives `grant`, `busy` and `link_request` high after edge N+1.
- Ack latency: a `link_ack` transition is acted on 3 edges later (2 sync stages plus the FSM edge).
- Minimum transfer with an instant slave: 1 (grant) + 3 (ack rise) + `SETUP_CYC` + 3 (ack fall) + 1 (DONE) cycles.
- Back-to-back transfers: IDLE is held for at least 1 cycle between transfers. A requester still high after DONE is re-arbitrated against `last`.
- Reset mid-transfer: all link outputs return to 0 on the next edge. The slave recovers through its own request/valid protocol.
- `req` dropping mid-transfer is ignored; the transfer completes.

## Structure
- Shared package `c2c_pkg` holds:
  - `C2C_DATA_W`=3.
  - State encodings: IDLE, REQ, SETUP, SEND, DONE, ABORT (3-bit).
  - Default `TIMEOUT_CYC`.
- Sub-module `sync_2ff` (1-bit, synchronous active-low reset to 0) synchronizes `link_ack`.
- The arbiter, FSM and counter stay in the top module.

## Test plan
- Single request:
  - Stimulus: `req`=01, `req_data0`=3'b101; slave model raises ack 10 cycles after request and drops it 5 cycles after valid.
  - Required: `grant`=01; `link_data`=5 appears `SETUP_CYC` cycles before `link_valid`; `link_request`=0 while valid is high; one `done` pulse; `link_data` returns to 0.
- Tie:
  - Stimulus: `req`=11 from reset, data0=2, data1=6, both held.
  - Required: transfers in order 1, 0, 1, 0 carrying data 6, 2, 6, 2; one `done` per transfer.
- Timeout in REQ:
  - Stimulus: `TIMEOUT_CYC`=50, slave never acks.
  - Required: `err` pulses exactly 50 cycles after entry to REQ; `done` never pulses; `link_*`=0; `busy`=0 the following cycle.
- Timeout in SEND:
  - Stimulus: ack held high forever.
  - Required: ABORT after `TIMEOUT_CYC` cycles in SEND; `link_valid` drops.
- Reset in SEND:
  - Stimulus: assert `rst_n`=0 for 1 cycle while in SEND.
  - Required: all outputs at reset values after that edge; a new `req` starts a fresh transfer.
- Data change after grant:
  - Stimulus: change `req_data0` from 1 to 7 while in REQ.
  - Required: slave receives 1.
